operand_fetch_unit: RTL and testbench
=====================================

// Module: operand_fetch_unit
// PURPOSE
//  Parametrised decode-to-execute operand stage, successor to the fixed 32x32 getoperands block.
//  Holds a 2R/1W register file, a write-back port, an immediate sign-extender and the RegDst/ALUSrc muxing.
//  Adds one registered output stage with valid/ready handshake, placing it between Get_Instruction and the ALU.
// PARAMETERS
//  DATA_W    32                 operand/register width in bits
//  NUM_REGS  32                 architectural register count; register 0 hardwired to zero
//  ADDR_W    $clog2(NUM_REGS)   register index width (derived; do not override)
//  IMM_W     16                 raw immediate width, sign-extended to DATA_W
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-low reset
//  in_valid       in   1        decode presents a valid instruction
//  in_ready       out  1        stage can accept this cycle
//  rs, rt, rd     in   ADDR_W   source/destination indices from decode
//  imm            in   IMM_W    raw immediate field
//  reg_dst        in   1        1: dest=rd, 0: dest=rt
//  alu_src        in   1        1: op2=sext(imm), 0: op2=R[rt]
//  reg_write      in   1        instruction writes dest (carried forward)
//  wb_en          in   1        write-back strobe
//  wb_addr        in   ADDR_W   write-back index
//  wb_data        in   DATA_W   write-back data
//  out_valid      out  1        op1/op2/dest/out_reg_write valid
//  out_ready      in   1        execute accepts
//  op1, op2       out  DATA_W   operands
//  dest           out  ADDR_W   selected destination index
//  out_reg_write  out  1        registered copy of reg_write
// BEHAVIOUR
//  - Reset (reset=0, async): all NUM_REGS registers <= 0; out_valid, op1, op2, dest, out_reg_write <= 0.
//  - Register file: write on posedge when wb_en && wb_addr!=0; writes to index 0 dropped; reads of 0 return 0.
//  - Read is combinational from rs/rt. Result is captured in the output register: 1-cycle latency in->out.
//  - Handshake: in_ready = !out_valid || out_ready. The stage loads on in_valid && in_ready.
//  - Handshake: out_valid is set on load and cleared when out_valid && out_ready && !load.
//  - Output payload is held stable while out_valid && !out_ready; rs/rt are not re-read during a stall.
//  - op2 = alu_src ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : R[rt]; dest = reg_dst ? rd : rt.
//  - Simultaneous accept and drain: new payload replaces old in the same edge, and out_valid stays 1.
//  - Index >= NUM_REGS (non-power-of-2 NUM_REGS): read returns 0 and the write is dropped.
//  - Reset asserted mid-stall: the held payload is discarded and out_valid=0 immediately.
// CONFIGURATION
//  OFU_BYPASS_EN defined:
//    - Same-cycle write-back forwarding: if wb_en && wb_addr==rs && rs!=0, the value captured for op1 is wb_data.
//    - The same forwarding applies to op2 when alu_src=0 and wb_addr==rt.
//  OFU_BYPASS_EN undefined:
//    - The captured operand is the pre-write register value; the new value is visible from the next cycle.
// STRUCTURE
//  - Package ofu_pkg holds: default DATA_W/NUM_REGS/IMM_W, a sign-extend function sext(imm), and the ZERO_REG=0 constant.
//  - Sub-module ofu_regfile_2r1w (NUM_REGS x DATA_W, async reset, r0 hardwired zero) contains the storage and the read ports.
//  - The top level contains the bypass muxes, the imm/RegDst muxing and the output valid/ready register.
// TESTING
//  1 reset: drop reset for 2 cycles, then read rs=5 rt=7 -> op1=0 op2=0 out_valid=0 during reset; out_valid=1 one cycle after in_valid.
//  2 wb_en, wb_addr=3, wb_data=0xDEADBEEF; next cycle rs=3 -> op1=0xDEADBEEF; a write to r0=0x55 followed by rs=0 -> op1=0.
//  3 alu_src=1, imm=16'hFFFE -> op2=0xFFFFFFFE; imm=16'h0004 -> op2=4; reg_dst=1 rd=9 rt=4 -> dest=9; reg_dst=0 -> dest=4.
//  4 stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and op1/op2 held; out_ready=1 -> drain and load in the same edge.
//  5 same cycle wb_addr=6 wb_data=0x11 and rs=6 (R6 old=0x22) -> op1=0x11 with OFU_BYPASS_EN, op1=0x22 without it.
//  6 assert reset while out_valid=1 && out_ready=0 -> out_valid=0 asynchronously and R3 reads 0 after release.

Source files
------------

// File: rtl/ofu_pkg.sv
// rtl/ofu_pkg.sv - shared defaults, zero-register index and sign-extend helper for the operand fetch unit
package ofu_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_IMM_W    = 16;
    localparam int ZERO_REG         = 0;

    // Width-generic sign extension: the low `width` bits of raw are extended to 64 bits
    function automatic logic [63:0] sext(input logic [63:0] raw, input int unsigned width);
        logic [63:0] shifted;
        shifted = raw << (64 - width);
        return $signed(shifted) >>> (64 - width);
    endfunction

endpackage

// File: rtl/ofu_regfile_2r1w.sv
// rtl/ofu_regfile_2r1w.sv - NUM_REGS x DATA_W register file, two async read ports, one write port, r0 hardwired zero
module ofu_regfile_2r1w
    import ofu_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Index 0 and indices past NUM_REGS behave as a constant-zero sink
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (a != ADDR_W'(ZERO_REG)) && (32'(a) < NUM_REGS);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && addr_live(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = addr_live(rd_addr1) ? mem[rd_addr1] : '0;
    assign rd_data2 = addr_live(rd_addr2) ? mem[rd_addr2] : '0;

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - decode-to-execute operand stage with valid/ready output register; OFU_BYPASS_EN enables write-back forwarding
module operand_fetch_unit
    import ofu_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int IMM_W    = DEFAULT_IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [IMM_W-1:0]  imm,
    input  logic              reg_dst,
    input  logic              alu_src,
    input  logic              reg_write,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [ADDR_W-1:0] dest,
    output logic              out_reg_write
);

    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic              load;

    ofu_regfile_2r1w #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (rs),
        .rd_data1 (rf_rs_data),
        .rd_addr2 (rt),
        .rd_data2 (rf_rt_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

`ifdef OFU_BYPASS_EN
    logic wb_live;

    // Only forward writes the register file would actually commit
    assign wb_live = wb_en && (wb_addr != ADDR_W'(ZERO_REG)) && (32'(wb_addr) < NUM_REGS);
    assign rs_data = (wb_live && (wb_addr == rs)) ? wb_data : rf_rs_data;
    assign rt_data = (wb_live && (wb_addr == rt)) ? wb_data : rf_rt_data;
`else
    assign rs_data = rf_rs_data;
    assign rt_data = rf_rt_data;
`endif

    assign imm_ext  = DATA_W'(sext(64'(imm), IMM_W));
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Payload only moves on load, so it stays frozen through a stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            op1           <= '0;
            op2           <= '0;
            dest          <= '0;
            out_reg_write <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            op1           <= rs_data;
            op2           <= alu_src ? imm_ext : rt_data;
            dest          <= reg_dst ? rd : rt;
            out_reg_write <= reg_write;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed table, corner sequences and randomized model check for operand_fetch_unit
module tb_operand_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        reg_dst, alu_src, reg_write;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1, op2;
    logic [4:0]  dest;
    logic        out_reg_write;

    int checks = 0;
    int errors = 0;

    operand_fetch_unit dut (
        .clk           (clk),
        .reset         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm           (imm),
        .reg_dst       (reg_dst),
        .alu_src       (alu_src),
        .reg_write     (reg_write),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op1           (op1),
        .op2           (op2),
        .dest          (dest),
        .out_reg_write (out_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        reg_dst, alu_src, reg_write;
        logic [31:0] exp_op1, exp_op2;
        logic [4:0]  exp_dest;
    } vec_t;

    vec_t vecs[5];

    // Behavioural reference: architectural registers plus the one in-flight result slot
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_dest;
    logic        m_rw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] d, input logic w);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_op1"}, op1, a);
        check({tag, "_op2"}, op2, b);
        check({tag, "_dest"}, 32'(dest), 32'(d));
        check({tag, "_rw"}, 32'(out_reg_write), 32'(w));
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_regs[idx];
    endfunction

    // Advances the model across one rising edge using the currently driven inputs
    task automatic model_edge;
        logic [31:0] a, b;
        if (in_valid && (!m_valid || out_ready)) begin
            a = m_read(rs);
            b = m_read(rt);
`ifdef OFU_BYPASS_EN
            if (wb_en && wb_addr != 0 && wb_addr == rs) a = wb_data;
            if (wb_en && wb_addr != 0 && wb_addr == rt) b = wb_data;
`endif
            m_op1   = a;
            m_op2   = alu_src ? 32'($signed(imm)) : b;
            m_dest  = reg_dst ? rd : rt;
            m_rw    = reg_write;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    endtask

    initial begin
        vecs[0] = '{rs:3, rt:7, rd:0,  imm:16'h0000, reg_dst:0, alu_src:0, reg_write:1,
                    exp_op1:32'hDEADBEEF, exp_op2:32'h77,       exp_dest:7};
        vecs[1] = '{rs:0, rt:4, rd:9,  imm:16'hFFFE, reg_dst:1, alu_src:1, reg_write:0,
                    exp_op1:32'h0,        exp_op2:32'hFFFFFFFE, exp_dest:9};
        vecs[2] = '{rs:4, rt:4, rd:9,  imm:16'h0004, reg_dst:0, alu_src:1, reg_write:1,
                    exp_op1:32'h44,       exp_op2:32'h4,        exp_dest:4};
        vecs[3] = '{rs:7, rt:0, rd:1,  imm:16'h8000, reg_dst:1, alu_src:1, reg_write:0,
                    exp_op1:32'h77,       exp_op2:32'hFFFF8000, exp_dest:1};
        vecs[4] = '{rs:5, rt:3, rd:31, imm:16'h7FFF, reg_dst:1, alu_src:0, reg_write:1,
                    exp_op1:32'h0,        exp_op2:32'hDEADBEEF, exp_dest:31};

        // Reset held for two cycles while a read is presented
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        rs = 5; rt = 7; rd = 0; imm = '0; reg_dst = 0; alu_src = 0; reg_write = 0;
        wb_en = 0; wb_addr = 0; wb_data = '0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check_out("reset", 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick;
        check_out("first_load", 1'b1, 32'd0, 32'd0, 5'd7, 1'b0);

        // Write-back then read, and r0 write suppression
        in_valid = 0; wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        tick;
        check("drain_valid", 32'(out_valid), 32'd0);
        wb_en = 0; in_valid = 1; rs = 3;
        tick;
        check("wb_read_r3", op1, 32'hDEADBEEF);
        in_valid = 0; wb_en = 1; wb_addr = 0; wb_data = 32'h55;
        tick;
        wb_en = 0; in_valid = 1; rs = 0;
        tick;
        check("r0_read", op1, 32'd0);
        in_valid = 0; wb_en = 1; wb_addr = 4; wb_data = 32'h44;
        tick;
        wb_addr = 7; wb_data = 32'h77;
        tick;
        wb_en = 0;

        // Table: imm sign extension, RegDst/ALUSrc muxing
        in_valid = 1; out_ready = 1;
        foreach (vecs[i]) begin
            rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; imm = vecs[i].imm;
            reg_dst = vecs[i].reg_dst; alu_src = vecs[i].alu_src; reg_write = vecs[i].reg_write;
            tick;
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_op1, vecs[i].exp_op2,
                      vecs[i].exp_dest, vecs[i].reg_write);
        end

        // Stall: payload from vec4 held, rs=5 rewritten but not re-read
        out_ready = 0; in_valid = 1; rs = 7; rt = 4; alu_src = 0; reg_dst = 0; reg_write = 0;
        wb_en = 1; wb_addr = 5; wb_data = 32'h55;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            wb_en = 0;
            check("stall_in_ready_hold", 32'(in_ready), 32'd0);
            check_out("stall", 1'b1, 32'h0, 32'hDEADBEEF, 5'd31, 1'b1);
        end
        out_ready = 1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'd1);
        tick;
        check_out("drain_load", 1'b1, 32'h77, 32'h44, 5'd4, 1'b0);

        // Same-cycle write-back versus read of R6
        in_valid = 0; wb_en = 1; wb_addr = 6; wb_data = 32'h22;
        tick;
        wb_data = 32'h11; in_valid = 1; rs = 6; rt = 0; alu_src = 0;
        tick;
`ifdef OFU_BYPASS_EN
        check("bypass_op1", op1, 32'h11);
`else
        check("nobypass_op1", op1, 32'h22);
`endif
        wb_en = 0;
        tick;
        check("after_wb_op1", op1, 32'h11);

        // Asynchronous reset during a stall
        rs = 3; out_ready = 1; in_valid = 1;
        tick;
        check("pre_reset_op1", op1, 32'hDEADBEEF);
        out_ready = 0; in_valid = 0;
        tick;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_op1", op1, 32'd0);
        tick;
        rst_n = 1'b1; in_valid = 1; out_ready = 1; rs = 3;
        tick;
        check_out("post_reset_r3", 1'b1, 32'd0, 32'd0, 5'd0, 1'b0);

        // Randomized traffic against the model, starting from a fresh reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_op1 = '0; m_op2 = '0; m_dest = '0; m_rw = 0;
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 5) < 3;
            rs        = 5'($urandom % 8);
            rt        = 5'($urandom % 8);
            rd        = 5'($urandom);
            imm       = 16'($urandom);
            reg_dst   = 1'($urandom);
            alu_src   = 1'($urandom);
            reg_write = 1'($urandom);
            wb_en     = 1'($urandom);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            model_edge();
            tick;
            check_out("rnd", m_valid, m_op1, m_op2, m_dest, m_rw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
